ball_motion_engine: RTL and testbench

- Per-frame physics engine for the ball-rolling game. It replaces the inline ball update with a parametrised, sequenced FSM.
- On each end-of-frame tick it queries an external collision map through a req/ack handshake, then bounces, moves, accelerates from the buttons, decelerates and checks the finish zone.
- It latches a sticky victory flag, which only an explicit restart clears.
- It sits between the frame timing logic and the renderer/collision ROMs.

---
 rtl/ball_motion_engine_pkg.sv | 41 ++++
 rtl/ball_motion_engine_if.sv | 15 +
 rtl/ball_motion_engine_axis_integrator.sv | 32 +++
 rtl/ball_motion_engine.sv | 165 ++++++++++++++++
 tb/tb_ball_motion_engine.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ball_motion_engine_pkg.sv
// Shared types and arithmetic helpers for the per-frame ball physics engine.
// Helpers work in int so they stay valid for any coordinate/speed width choice.
package ball_motion_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int SPEED_W_DEF = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BOUNCE,
    S_MOVE,
    S_ACCEL,
    S_DECEL,
    S_FINISH,
    S_WON
  } state_t;

  // One friction step: moves a speed one unit toward zero, snapping |v|<=1 to 0.
  function automatic int friction_step(input int v);
    if (v >= -1 && v <= 1) return 0;
    return (v > 0) ? v - 1 : v + 1;
  endfunction

  function automatic int sat_add(input int v, input int d, input int lim);
    int s;
    s = v + d;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

  function automatic int dist2(input int ax, input int ay, input int bx, input int by);
    int dx;
    int dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return dx * dx + dy * dy;
  endfunction

endpackage

// File: rtl/ball_motion_engine_if.sv
// Collision-map lookup handshake: engine raises coll_req with a stable position,
// the map answers with coll_ack plus hit bits valid in the same cycle.
interface ball_motion_engine_if #(
  parameter int COORD_W = 10
);
  logic               coll_req;
  logic [COORD_W-1:0] coll_x;
  logic [COORD_W-1:0] coll_y;
  logic               coll_ack;
  logic               coll_hit_x;
  logic               coll_hit_y;

  modport master (output coll_req, coll_x, coll_y, input coll_ack, coll_hit_x, coll_hit_y);
  modport slave  (input coll_req, coll_x, coll_y, output coll_ack, coll_hit_x, coll_hit_y);
endinterface

// File: rtl/ball_motion_engine_axis_integrator.sv
// One axis of the MOVE step: position plus speed, clamped to [0, EXTENT-1],
// with the speed reflected whenever the clamp engages. Purely combinational.
module axis_integrator #(
  parameter int COORD_W = 10,
  parameter int SPEED_W = 6,
  parameter int EXTENT  = 800
) (
  input  logic        [COORD_W-1:0] pos,
  input  logic signed [SPEED_W-1:0] speed,
  output logic        [COORD_W-1:0] pos_next,
  output logic signed [SPEED_W-1:0] speed_next
);

  localparam logic signed [COORD_W:0] POS_MAX = (COORD_W+1)'(EXTENT - 1);

  logic signed [COORD_W:0] sum;

  assign sum = $signed({1'b0, pos}) + $signed({{(COORD_W+1-SPEED_W){speed[SPEED_W-1]}}, speed});

  always_comb begin
    pos_next   = sum[COORD_W-1:0];
    speed_next = speed;
    if (sum[COORD_W]) begin
      pos_next   = '0;
      speed_next = -speed;
    end else if (sum > POS_MAX) begin
      pos_next   = POS_MAX[COORD_W-1:0];
      speed_next = -speed;
    end
  end

endmodule

// File: rtl/ball_motion_engine.sv
// Sequenced per-frame ball update: collide, bounce, move, accelerate, brake, finish check.
// Position lands 4 cycles after frame_tick (zero-wait ack); ticks arriving while busy are dropped with an overrun pulse.
module ball_motion_engine
  import ball_motion_pkg::*;
#(
  parameter int COORD_W      = COORD_W_DEF,
  parameter int SPEED_W      = SPEED_W_DEF,
  parameter int SCREEN_W     = 800,
  parameter int SCREEN_H     = 600,
  parameter int START_X      = 400,
  parameter int START_Y      = 300,
  parameter int DECEL_PERIOD = 5,
  parameter int MAX_SPEED    = 15,
  parameter int R2_SLOW      = 144,
  parameter int R2_WIN       = 81,
  parameter int V2_WIN       = 36
) (
  input  logic                      pixel_clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      restart,
  input  logic                      btn_l,
  input  logic                      btn_r,
  input  logic                      btn_u,
  input  logic                      btn_d,
  input  logic        [COORD_W-1:0] finish_x,
  input  logic        [COORD_W-1:0] finish_y,
  ball_motion_engine_if.master      coll,
  output logic        [COORD_W-1:0] ball_x,
  output logic        [COORD_W-1:0] ball_y,
  output logic signed [SPEED_W-1:0] speed_x,
  output logic signed [SPEED_W-1:0] speed_y,
  output logic                      busy,
  output logic                      victory,
  output logic                      overrun
);

  localparam int CNT_W = (DECEL_PERIOD > 1) ? $clog2(DECEL_PERIOD) : 1;

  state_t             state;
  logic               req_q;
  logic               hit_x;
  logic               hit_y;
  logic [CNT_W-1:0]   decel_cnt;

  logic        [COORD_W-1:0] move_x, move_y;
  logic signed [SPEED_W-1:0] move_sx, move_sy;

  int  acc_x, acc_y, dec_x, dec_y, fin_x, fin_y, d2, v2;
  logic win;

  // Ball cannot move during REQ, so the live position doubles as the stable lookup address.
  assign coll.coll_req = req_q;
  assign coll.coll_x   = ball_x;
  assign coll.coll_y   = ball_y;

  axis_integrator #(.COORD_W(COORD_W), .SPEED_W(SPEED_W), .EXTENT(SCREEN_W)) u_axis_x (
    .pos(ball_x), .speed(speed_x), .pos_next(move_x), .speed_next(move_sx)
  );

  axis_integrator #(.COORD_W(COORD_W), .SPEED_W(SPEED_W), .EXTENT(SCREEN_H)) u_axis_y (
    .pos(ball_y), .speed(speed_y), .pos_next(move_y), .speed_next(move_sy)
  );

  always_comb begin
    acc_x = sat_add(int'(speed_x), int'(btn_r) - int'(btn_l), MAX_SPEED);
    acc_y = sat_add(int'(speed_y), int'(btn_d) - int'(btn_u), MAX_SPEED);
    dec_x = friction_step(int'(speed_x));
    dec_y = friction_step(int'(speed_y));
    d2    = dist2(int'(ball_x), int'(ball_y), int'(finish_x), int'(finish_y));
    // Braking inside the slow zone happens before the win test sees the speed.
    fin_x = (d2 < R2_SLOW) ? dec_x : int'(speed_x);
    fin_y = (d2 < R2_SLOW) ? dec_y : int'(speed_y);
    v2    = fin_x * fin_x + fin_y * fin_y;
    win   = (d2 < R2_WIN) && (v2 < V2_WIN);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      decel_cnt <= '0;
      ball_x    <= COORD_W'(START_X);
      ball_y    <= COORD_W'(START_Y);
      speed_x   <= '0;
      speed_y   <= '0;
      busy      <= 1'b0;
      victory   <= 1'b0;
      overrun   <= 1'b0;
    end else if (restart) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      decel_cnt <= '0;
      ball_x    <= COORD_W'(START_X);
      ball_y    <= COORD_W'(START_Y);
      speed_x   <= '0;
      speed_y   <= '0;
      busy      <= 1'b0;
      victory   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= frame_tick && busy;
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            state <= S_REQ;
            req_q <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_REQ: begin
          if (coll.coll_ack) begin
            hit_x <= coll.coll_hit_x;
            hit_y <= coll.coll_hit_y;
            req_q <= 1'b0;
            state <= S_BOUNCE;
          end
        end
        S_BOUNCE: begin
          if (hit_x) speed_x <= -speed_x;
          if (hit_y) speed_y <= -speed_y;
          state <= S_MOVE;
        end
        S_MOVE: begin
          ball_x  <= move_x;
          ball_y  <= move_y;
          speed_x <= move_sx;
          speed_y <= move_sy;
          state   <= S_ACCEL;
        end
        S_ACCEL: begin
          speed_x <= SPEED_W'(acc_x);
          speed_y <= SPEED_W'(acc_y);
          state   <= S_DECEL;
        end
        S_DECEL: begin
          if (decel_cnt == '0) begin
            speed_x <= SPEED_W'(dec_x);
            speed_y <= SPEED_W'(dec_y);
          end
          decel_cnt <= (decel_cnt == CNT_W'(DECEL_PERIOD - 1)) ? '0 : decel_cnt + 1'b1;
          state     <= S_FINISH;
        end
        S_FINISH: begin
          busy <= 1'b0;
          if (win) begin
            victory <= 1'b1;
            speed_x <= '0;
            speed_y <= '0;
            state   <= S_WON;
          end else begin
            speed_x <= SPEED_W'(fin_x);
            speed_y <= SPEED_W'(fin_y);
            state   <= S_IDLE;
          end
        end
        S_WON: state <= S_WON;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine with hand-computed trajectories.
module tb_ball_motion_engine;

  logic               pixel_clk = 1'b0;
  logic               rst_n;
  logic               frame_tick, restart;
  logic               btn_l, btn_r, btn_u, btn_d;
  logic [9:0]         finish_x, finish_y;
  logic [9:0]         ball_x, ball_y;
  logic signed [5:0]  speed_x, speed_y;
  logic               busy, victory, overrun;

  int checks   = 0;
  int failures = 0;

  always #5 pixel_clk = ~pixel_clk;

  ball_motion_engine_if #(.COORD_W(10)) coll_bus ();

  ball_motion_engine dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .restart   (restart),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .btn_u     (btn_u),
    .btn_d     (btn_d),
    .finish_x  (finish_x),
    .finish_y  (finish_y),
    .coll      (coll_bus),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .speed_x   (speed_x),
    .speed_y   (speed_y),
    .busy      (busy),
    .victory   (victory),
    .overrun   (overrun)
  );

  task automatic check_val(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_frame();
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
  endtask

  task automatic finish_frame(input logic hx, input logic hy);
    int n;
    n = 0;
    coll_bus.coll_ack   = 1'b1;
    coll_bus.coll_hit_x = hx;
    coll_bus.coll_hit_y = hy;
    @(negedge pixel_clk);
    coll_bus.coll_ack   = 1'b0;
    coll_bus.coll_hit_x = 1'b0;
    coll_bus.coll_hit_y = 1'b0;
    while (busy && n < 20) begin
      @(negedge pixel_clk);
      n++;
    end
    check_val("frame_done", busy, 0);
  endtask

  task automatic run_frames(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      start_frame();
      finish_frame(1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; restart = 1'b0;
    btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
    finish_x = 10'd0; finish_y = 10'd0;
    coll_bus.coll_ack = 1'b0; coll_bus.coll_hit_x = 1'b0; coll_bus.coll_hit_y = 1'b0;
    repeat (2) @(negedge pixel_clk);
    check_val("rst_ball_x", ball_x, 400);
    check_val("rst_ball_y", ball_y, 300);
    check_val("rst_speed_x", speed_x, 0);
    check_val("rst_speed_y", speed_y, 0);
    check_val("rst_coll_req", coll_bus.coll_req, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_victory", victory, 0);
    check_val("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(negedge pixel_clk);

    // Free motion with btn_r; friction lands on the first frame of every five.
    btn_r = 1'b1;
    run_frames(4);
    check_val("free_x_f4", ball_x, 403);
    check_val("free_sx_f4", speed_x, 3);
    run_frames(1);
    check_val("free_x_f5", ball_x, 406);
    check_val("free_sx_f5", speed_x, 4);
    run_frames(1);
    check_val("free_x_f6", ball_x, 410);
    check_val("friction_sx_f6", speed_x, 4);
    btn_r = 1'b0;

    // Latency walk of one zero-wait frame.
    start_frame();
    check_val("lat_req", coll_bus.coll_req, 1);
    check_val("lat_coll_x", coll_bus.coll_x, 410);
    check_val("lat_busy", busy, 1);
    coll_bus.coll_ack = 1'b1;
    @(negedge pixel_clk);
    coll_bus.coll_ack = 1'b0;
    check_val("lat_req_drop", coll_bus.coll_req, 0);
    @(negedge pixel_clk);
    check_val("lat_pre_move", ball_x, 410);
    @(negedge pixel_clk);
    check_val("lat_t4_x", ball_x, 414);
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    check_val("lat_t6_busy", busy, 1);
    @(negedge pixel_clk);
    check_val("lat_t7_busy", busy, 0);

    // Delayed ack with a vertical-wall hit.
    start_frame();
    for (int i = 0; i < 7; i++) begin
      check_val("hs_req_hold", coll_bus.coll_req, 1);
      check_val("hs_x_hold", coll_bus.coll_x, 414);
      @(negedge pixel_clk);
    end
    finish_frame(1'b1, 1'b0);
    check_val("bounce_x", ball_x, 410);
    check_val("bounce_sx", speed_x, -4);

    // Tick while busy.
    start_frame();
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    check_val("overrun_pulse", overrun, 1);
    @(negedge pixel_clk);
    check_val("overrun_clear", overrun, 0);
    finish_frame(1'b0, 1'b0);
    repeat (3) @(negedge pixel_clk);
    check_val("tick_dropped_busy", busy, 0);
    check_val("overrun_once_x", ball_x, 406);

    // Restart mid-handshake, then restart coinciding with a tick.
    start_frame();
    restart = 1'b1;
    @(negedge pixel_clk);
    restart = 1'b0;
    check_val("abort_req", coll_bus.coll_req, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_x", ball_x, 400);
    check_val("abort_sx", speed_x, 0);
    restart = 1'b1; frame_tick = 1'b1;
    @(negedge pixel_clk);
    restart = 1'b0; frame_tick = 1'b0;
    @(negedge pixel_clk);
    check_val("restart_tick_busy", busy, 0);
    check_val("restart_tick_req", coll_bus.coll_req, 0);

    // Saturation, cancel and right-wall clamp.
    btn_r = 1'b1;
    run_frames(20);
    check_val("sat_x_f20", ball_x, 544);
    check_val("sat_sx_f20", speed_x, 15);
    run_frames(3);
    check_val("sat_x_f23", ball_x, 588);
    check_val("sat_sx_f23", speed_x, 15);
    btn_l = 1'b1;
    run_frames(1);
    check_val("cancel_x", ball_x, 603);
    check_val("cancel_sx", speed_x, 15);
    btn_l = 1'b0;
    run_frames(13);
    check_val("prewall_x", ball_x, 795);
    btn_r = 1'b0;
    run_frames(1);
    check_val("wall_x", ball_x, 799);
    check_val("wall_sx", speed_x, -15);
    check_val("wall_y", ball_y, 300);

    // Approach the finish zone at (420,300): brake frame, then win.
    restart = 1'b1;
    @(negedge pixel_clk);
    restart = 1'b0;
    finish_x = 10'd420; finish_y = 10'd300;
    btn_r = 1'b1;
    run_frames(5);
    check_val("approach_x", ball_x, 406);
    check_val("approach_sx", speed_x, 4);
    btn_r = 1'b0;
    run_frames(1);
    check_val("brake_x", ball_x, 410);
    check_val("brake_sx", speed_x, 2);
    check_val("brake_no_win", victory, 0);
    run_frames(1);
    check_val("win_flag", victory, 1);
    check_val("win_x", ball_x, 412);
    check_val("win_sx", speed_x, 0);
    check_val("win_busy", busy, 0);

    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    check_val("won_no_overrun", overrun, 0);
    check_val("won_no_req", coll_bus.coll_req, 0);
    repeat (3) @(negedge pixel_clk);
    check_val("won_frozen_x", ball_x, 412);
    check_val("won_sticky", victory, 1);
    restart = 1'b1;
    @(negedge pixel_clk);
    restart = 1'b0;
    check_val("won_restart_x", ball_x, 400);
    check_val("won_restart_y", ball_y, 300);
    check_val("won_restart_vic", victory, 0);

    // Asynchronous reset in the middle of a frame.
    finish_x = 10'd0; finish_y = 10'd0;
    btn_r = 1'b1;
    run_frames(3);
    check_val("pre_arst_x", ball_x, 401);
    check_val("pre_arst_sx", speed_x, 2);
    start_frame();
    coll_bus.coll_ack = 1'b1;
    @(negedge pixel_clk);
    coll_bus.coll_ack = 1'b0;
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    check_val("mid_frame_x", ball_x, 403);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_x", ball_x, 400);
    check_val("arst_sx", speed_x, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_req", coll_bus.coll_req, 0);
    @(negedge pixel_clk);
    rst_n = 1'b1;
    btn_r = 1'b0;
    @(negedge pixel_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
